conv1_win_addr_seq: RTL and testbench

// - Sequencer for conv1 input-window fetch. Per ap_start it emits the 11x11x3 input-feature-map word addresses for one output pixel (oh, ow).
// - Output is a valid/ready address stream that drives the input-buffer read port ahead of the conv1 MAC datapath.
// - Channel/row offsets are accumulated incrementally, so no multiplier is inferred.

---
 rtl/conv1_pkg.sv | 37 +++
 rtl/conv1_win_addr_seq_if.sv | 27 ++
 rtl/conv1_win_cnt.sv | 75 +++++++
 rtl/conv1_win_addr_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_conv1_win_addr_seq.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/conv1_pkg.sv
// Shared conv1 window constants, FSM encoding and shift-add helpers.
// Used by conv1_win_addr_seq (optional bounds check: CONV1_ADDR_BOUNDS_CHK_EN).
package conv1_pkg;

  localparam int IN_W    = 227;
  localparam int IN_H    = 227;
  localparam int IN_C    = 3;
  localparam int K       = 11;
  localparam int STRIDE  = 4;
  localparam int OUT_W   = 55;
  localparam int ADDR_W  = 20;
  localparam int PLANE   = IN_W * IN_H;
  localparam int WIN_LEN = IN_C * K * K;

  localparam logic [ADDR_W-1:0] IN_W_A  = 20'd227;
  localparam logic [ADDR_W-1:0] PLANE_A = 20'd51529;
  localparam logic [5:0]        OUT_W_L = 6'd55;
  localparam logic [3:0]        K_LAST  = 4'd10;
  localparam logic [1:0]        C_LAST  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // v*227 as 128+64+32+2+1 so no multiplier is built
  function automatic logic [ADDR_W-1:0] mul_in_w(input logic [ADDR_W-1:0] v);
    return (v << 3'd7) + (v << 3'd6) + (v << 3'd5) + (v << 3'd1) + v;
  endfunction

  function automatic logic [ADDR_W-1:0] scale_stride(input logic [5:0] v);
    return {12'd0, v, 2'b00};
  endfunction

endpackage

// File: rtl/conv1_win_addr_seq_if.sv
// Start/status and address-stream signals of the conv1 window sequencer.
interface conv1_win_addr_seq_if;
  import conv1_pkg::*;

  logic              ap_start;
  logic [5:0]        oh;
  logic [5:0]        ow;
  logic              ap_ready;
  logic              ap_idle;
  logic              ap_done;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid;
  logic              addr_ready;
  logic              addr_last;
  logic              err;

  modport master (
    input  ap_start, oh, ow, addr_ready,
    output ap_ready, ap_idle, ap_done, addr_out, addr_valid, addr_last, err
  );

  modport slave (
    output ap_start, oh, ow, addr_ready,
    input  ap_ready, ap_idle, ap_done, addr_out, addr_valid, addr_last, err
  );

endinterface

// File: rtl/conv1_win_cnt.sv
// Nested kw/kh/kc window counters with wrap flags and current/next last detect.
module conv1_win_cnt
  import conv1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] kw,
  output logic [3:0] kw_nxt,
  output logic       kw_wrap,
  output logic       kh_wrap,
  output logic       last,
  output logic       last_nxt
);

  logic [3:0] kw_r;
  logic [3:0] kh_r;
  logic [1:0] kc_r;
  logic [3:0] kw_nxt_s;
  logic [3:0] kh_nxt_s;
  logic [1:0] kc_nxt_s;
  logic       kw_wrap_s;
  logic       kh_wrap_s;

  assign kw_wrap_s = (kw_r == K_LAST);
  assign kh_wrap_s = (kh_r == K_LAST);

  // Counter values after one more accepted address
  always_comb begin
    kw_nxt_s = kw_r + 4'd1;
    kh_nxt_s = kh_r;
    kc_nxt_s = kc_r;
    if (kw_wrap_s) begin
      kw_nxt_s = 4'd0;
      if (kh_wrap_s) begin
        kh_nxt_s = 4'd0;
        if (kc_r == C_LAST) begin
          kc_nxt_s = 2'd0;
        end else begin
          kc_nxt_s = kc_r + 2'd1;
        end
      end else begin
        kh_nxt_s = kh_r + 4'd1;
      end
    end else begin
      kh_nxt_s = kh_r;
    end
  end

  // Counter registers: cleared on window load, advanced per handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kw_r <= 4'd0;
      kh_r <= 4'd0;
      kc_r <= 2'd0;
    end else if (clr) begin
      kw_r <= 4'd0;
      kh_r <= 4'd0;
      kc_r <= 2'd0;
    end else if (en) begin
      kw_r <= kw_nxt_s;
      kh_r <= kh_nxt_s;
      kc_r <= kc_nxt_s;
    end
  end

  assign kw       = kw_r;
  assign kw_nxt   = kw_nxt_s;
  assign kw_wrap  = kw_wrap_s;
  assign kh_wrap  = kh_wrap_s;
  assign last     = (kc_r == C_LAST) && kh_wrap_s && kw_wrap_s;
  assign last_nxt = (kc_nxt_s == C_LAST) && (kh_nxt_s == K_LAST) && (kw_nxt_s == K_LAST);

endmodule

// File: rtl/conv1_win_addr_seq.sv
// conv1 input-window address sequencer: 363 addresses per start, valid/ready out.
// Optional oh/ow bounds check with abort enabled by CONV1_ADDR_BOUNDS_CHK_EN.
module conv1_win_addr_seq
  import conv1_pkg::*;
(
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  conv1_win_addr_seq_if.master  bus
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic              accept_s;
  logic              load_s;
  logic              present_s;
  logic              hs_s;
  logic              oob_s;

  logic [5:0]        oh_r;
  logic [5:0]        ow_r;
  logic [ADDR_W-1:0] row_base_off_r;
  logic [ADDR_W-1:0] col_base_r;
  logic [ADDR_W-1:0] row_off_r;
  logic [ADDR_W-1:0] ch_off_r;
  logic [ADDR_W-1:0] row_off_nxt_s;
  logic [ADDR_W-1:0] ch_off_nxt_s;
  logic [ADDR_W-1:0] addr_cur_s;
  logic [ADDR_W-1:0] addr_nxt_s;

  logic [ADDR_W-1:0] addr_r;
  logic              valid_r;
  logic              last_r;
  logic              ap_ready_r;
  logic              ap_idle_r;
  logic              ap_done_r;

  logic [3:0]        kw_s;
  logic [3:0]        kw_nxt_s;
  logic              kw_wrap_s;
  logic              kh_wrap_s;
  logic              last_cur_s;
  logic              last_nxt_s;

  conv1_win_cnt u_cnt (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .clr      (load_s),
    .en       (hs_s),
    .kw       (kw_s),
    .kw_nxt   (kw_nxt_s),
    .kw_wrap  (kw_wrap_s),
    .kh_wrap  (kh_wrap_s),
    .last     (last_cur_s),
    .last_nxt (last_nxt_s)
  );

`ifdef CONV1_ADDR_BOUNDS_CHK_EN
  assign oob_s = (oh_r >= OUT_W_L) || (ow_r >= OUT_W_L);
`else
  assign oob_s = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and per-cycle datapath strobes
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    load_s      = 1'b0;
    present_s   = 1'b0;
    hs_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.ap_start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (oob_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          load_s      = 1'b1;
          state_nxt_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!valid_r) begin
          present_s = 1'b1;
        end else if (bus.addr_ready) begin
          hs_s = 1'b1;
          if (last_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Offsets that apply once the current address is accepted
  always_comb begin
    row_off_nxt_s = row_off_r;
    ch_off_nxt_s  = ch_off_r;
    if (kw_wrap_s) begin
      if (kh_wrap_s) begin
        row_off_nxt_s = row_base_off_r;
        ch_off_nxt_s  = ch_off_r + PLANE_A;
      end else begin
        row_off_nxt_s = row_off_r + IN_W_A;
      end
    end else begin
      row_off_nxt_s = row_off_r;
    end
  end

  assign addr_cur_s = ch_off_r + row_off_r + col_base_r + {16'd0, kw_s};
  assign addr_nxt_s = ch_off_nxt_s + row_off_nxt_s + col_base_r + {16'd0, kw_nxt_s};

  // Latched window position and incremental offset accumulators
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      oh_r           <= 6'd0;
      ow_r           <= 6'd0;
      row_base_off_r <= 20'd0;
      col_base_r     <= 20'd0;
      row_off_r      <= 20'd0;
      ch_off_r       <= 20'd0;
    end else begin
      if (accept_s) begin
        oh_r <= bus.oh;
        ow_r <= bus.ow;
      end
      if (load_s) begin
        col_base_r     <= scale_stride(ow_r);
        row_base_off_r <= mul_in_w(scale_stride(oh_r));
        row_off_r      <= mul_in_w(scale_stride(oh_r));
        ch_off_r       <= 20'd0;
      end else if (hs_s) begin
        row_off_r <= row_off_nxt_s;
        ch_off_r  <= ch_off_nxt_s;
      end
    end
  end

  // Address output register: holds across stalls, drops on final handshake
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      addr_r  <= 20'd0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (present_s) begin
      addr_r  <= addr_cur_s;
      valid_r <= 1'b1;
      last_r  <= last_cur_s;
    end else if (hs_s) begin
      if (last_r) begin
        addr_r  <= 20'd0;
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end else begin
        addr_r  <= addr_nxt_s;
        valid_r <= 1'b1;
        last_r  <= last_nxt_s;
      end
    end
  end

  // Control status outputs, registered from the next state
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ap_ready_r <= 1'b0;
      ap_idle_r  <= 1'b1;
      ap_done_r  <= 1'b0;
    end else begin
      ap_ready_r <= accept_s;
      ap_idle_r  <= (state_nxt_s == ST_IDLE);
      ap_done_r  <= (state_nxt_s == ST_DONE);
    end
  end

`ifdef CONV1_ADDR_BOUNDS_CHK_EN
  logic err_r;

  // Sticky bounds error, cleared when the next window is accepted
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_LOAD) && oob_s) begin
      err_r <= 1'b1;
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.addr_out   = addr_r;
  assign bus.addr_valid = valid_r;
  assign bus.addr_last  = last_r;
  assign bus.ap_ready   = ap_ready_r;
  assign bus.ap_idle    = ap_idle_r;
  assign bus.ap_done    = ap_done_r;

endmodule

// File: tb/tb_conv1_win_addr_seq.sv
// Randomised bench for conv1_win_addr_seq against a nested-loop address model.
module tb_conv1_win_addr_seq;

  logic ap_clk;
  logic ap_rst_n;
  int   n_checks;
  int   n_fail;

  conv1_win_addr_seq_if sig ();

  conv1_win_addr_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (sig.master)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a window and follow it to ap_done (or abort after abort_after handshakes).
  task automatic run_window(input int w_oh, input int w_ow, input int hold,
                            input int rdy_pct, input int abort_after);
    int exp_a[363];
    int idx, cyc, lat, rdy_seen, got, fin, hs, stalled;
    logic [19:0] prev_a;
    logic        prev_l;
    for (int c = 0; c < 3; c++)
      for (int h = 0; h < 11; h++)
        for (int w = 0; w < 11; w++)
          exp_a[c*121 + h*11 + w] = c*227*227 + (w_oh*4 + h)*227 + w_ow*4 + w;

    sig.oh       = w_oh[5:0];
    sig.ow       = w_ow[5:0];
    sig.ap_start = 1'b1;
    got = 0;
    for (int i = 0; i < 12 && got == 0; i++) begin
      @(posedge ap_clk); #1;
      if (sig.ap_ready) got = 1;
    end
    check_eq("start_accept", got, 1);
    check_eq("idle_low", sig.ap_idle, 0);
    check_eq("err_clear", sig.err, 0);
    if (hold == 0) sig.ap_start = 1'b0;

    idx = 0; cyc = 0; lat = -1; rdy_seen = 0; fin = 0; stalled = 0;
    prev_a = 20'd0; prev_l = 1'b0;
    while (fin == 0) begin
      if (cyc > 0 && sig.ap_ready) rdy_seen++;
      if (stalled != 0) begin
        check_eq("stall_valid", sig.addr_valid, 1);
        check_eq("stall_addr", sig.addr_out, prev_a);
        check_eq("stall_last", sig.addr_last, prev_l);
      end
      if (sig.addr_valid && lat < 0) lat = cyc;
      sig.addr_ready = (int'($urandom_range(99)) < rdy_pct);
      hs      = (sig.addr_valid && sig.addr_ready) ? 1 : 0;
      stalled = (sig.addr_valid && !sig.addr_ready) ? 1 : 0;
      prev_a  = sig.addr_out;
      prev_l  = sig.addr_last;
      if (hs != 0) begin
        if (idx < 363) begin
          check_eq("addr", sig.addr_out, exp_a[idx]);
          check_eq("last", sig.addr_last, (idx == 362) ? 1 : 0);
        end else begin
          check_eq("extra_handshake", idx, 362);
        end
        idx++;
      end
      @(posedge ap_clk); #1;
      cyc++;
      if (hs != 0 && idx == 363) begin
        check_eq("done_pulse", sig.ap_done, 1);
        check_eq("valid_drop", sig.addr_valid, 0);
        fin = 1;
      end else if (hs != 0 && abort_after > 0 && idx == abort_after) begin
        fin = 1;
      end else if (sig.ap_done) begin
        check_eq("early_done", idx, 363);
        fin = 1;
      end else if (cyc >= 4000) begin
        check_eq("timeout", cyc, 0);
        fin = 1;
      end
    end
    if (abort_after == 0) begin
      check_eq("handshakes", idx, 363);
      check_eq("first_valid_lat", lat, 2);
      check_eq("ready_once", rdy_seen, 0);
    end
  endtask

`ifdef CONV1_ADDR_BOUNDS_CHK_EN
  task automatic run_err(input int w_oh, input int w_ow);
    int got, done, vseen;
    sig.oh = w_oh[5:0];
    sig.ow = w_ow[5:0];
    sig.ap_start = 1'b1;
    got = 0;
    for (int i = 0; i < 12 && got == 0; i++) begin
      @(posedge ap_clk); #1;
      if (sig.ap_ready) got = 1;
    end
    check_eq("err_accept", got, 1);
    sig.ap_start = 1'b0;
    done = 0; vseen = 0;
    for (int i = 0; i < 10 && done == 0; i++) begin
      @(posedge ap_clk); #1;
      if (sig.addr_valid) vseen++;
      if (sig.ap_done) done = 1;
    end
    check_eq("err_done", done, 1);
    check_eq("err_set", sig.err, 1);
    check_eq("err_no_valid", vseen, 0);
    @(posedge ap_clk); #1;
    check_eq("err_sticky", sig.err, 1);
    check_eq("err_done_once", sig.ap_done, 0);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ap_rst_n = 1'b0;
    sig.ap_start   = 1'b0;
    sig.oh         = 6'd0;
    sig.ow         = 6'd0;
    sig.addr_ready = 1'b0;
    #22;
    check_eq("rst_idle", sig.ap_idle, 1);
    check_eq("rst_valid", sig.addr_valid, 0);
    check_eq("rst_addr", sig.addr_out, 0);
    check_eq("rst_ready", sig.ap_ready, 0);
    check_eq("rst_done", sig.ap_done, 0);
    check_eq("rst_last", sig.addr_last, 0);
    check_eq("rst_err", sig.err, 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    run_window(0, 0, 0, 100, 0);
    run_window(54, 54, 0, 100, 0);
    run_window(0, 0, 0, 50, 0);
    run_window(54, 54, 0, 40, 0);
    for (int n = 0; n < 4; n++)
      run_window($urandom_range(54), $urandom_range(54), 0, $urandom_range(30, 90), 0);

    run_window(7, 9, 1, 100, 0);
    run_window(7, 9, 0, 70, 0);

    run_window(0, 0, 0, 100, 100);
    ap_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", sig.addr_valid, 0);
    check_eq("mid_rst_addr", sig.addr_out, 0);
    check_eq("mid_rst_idle", sig.ap_idle, 1);
    check_eq("mid_rst_last", sig.addr_last, 0);
    check_eq("mid_rst_done", sig.ap_done, 0);
    #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    run_window(0, 0, 0, 100, 0);

`ifdef CONV1_ADDR_BOUNDS_CHK_EN
    run_err(55, 3);
    run_err(2, 60);
    run_window(1, 2, 0, 80, 0);
`else
    run_window(55, 0, 0, 80, 0);
    check_eq("err_tied", sig.err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
